voice_allocator: RTL
====================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter N_VOICES, default 4: number of carrier voices managed, 1..8.
REQ-002 Parameter FCW_WIDTH, default 24: carrier frequency control word width.
REQ-003 Parameter KEY_WIDTH, default 7: note key identifier width.
REQ-004 clk  in  1  single clock, cpu_clk domain.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 cmd_valid  in  1  note command offered.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_on  in  1  1 = note-on, 0 = note-off.
REQ-009 cmd_key  in  KEY_WIDTH  key identifier.
REQ-010 cmd_fcw  in  FCW_WIDTH  carrier FCW for note-on; ignored for note-off.
REQ-011 carrier_fcws  out  N_VOICES*FCW_WIDTH  per-voice FCW; voice i occupies bits [i*FCW_WIDTH +: FCW_WIDTH].
REQ-012 note_en  out  N_VOICES  per-voice enable.
REQ-013 tx_req  out  1  four-phase request toward the CPU-to-synth CDC.
REQ-014 tx_ack  in  1  four-phase acknowledge, already synchronized to clk.
REQ-015 drop  out  1  one-cycle pulse when a command is discarded.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, APPLY, REQ, ACKLOW.
REQ-017 cmd_ready SHALL be 1 only in IDLE; the command is accepted on the edge where cmd_valid && cmd_ready.
REQ-018 Accepted command: IDLE -> APPLY; the chosen voice and the operation are registered.
REQ-019 APPLY SHALL update carrier_fcws, note_en, and ages on the next edge, then go to REQ with tx_req=1. Outputs SHALL change exactly 2 edges after acceptance.
REQ-020 REQ: tx_req SHALL stay 1 until tx_ack is sampled 1, then go to ACKLOW with tx_req=0.
REQ-021 ACKLOW: the FSM SHALL wait for tx_ack sampled 0, then return to IDLE.
REQ-022 carrier_fcws and note_en SHALL NOT change outside APPLY.
REQ-023 Note-on voice choice, in priority order: (a) an enabled voice already holding cmd_key (retrigger); (b) the lowest-index disabled voice; (c) full-case rule (REQ-034/035).
REQ-024 Note-on SHALL write cmd_fcw, set note_en, store cmd_key, and make that voice youngest.
REQ-025 Note-off SHALL clear note_en of the enabled voice with matching key, leaving its FCW unchanged.
REQ-026 Note-off with no match: APPLY -> IDLE, no output change, no tx_req, drop pulses 1 cycle.
REQ-027 Age: each voice SHALL hold a rank 0..N_VOICES-1, where 0 is youngest. On allocation, the chosen voice becomes rank 0 and voices with a smaller old rank increment by 1. Ranks SHALL stay a permutation.
REQ-028 cmd_valid while not in IDLE SHALL be ignored (held off, not lost, by the sender).
REQ-029 tx_ack already 1 on entry to REQ SHALL complete REQ in one cycle.

Reset
REQ-030 On rst, asynchronously: state=IDLE, carrier_fcws=0, note_en=0, tx_req=0, drop=0, and stored keys=0.
REQ-031 On rst, voice i rank SHALL be i.
REQ-032 cmd_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-033 rst mid-handshake SHALL drop tx_req immediately. The partial command is discarded.

Configuration
REQ-034 With VOICE_STEAL_EN defined, note-on with all voices enabled and no key match SHALL take the oldest voice (rank N_VOICES-1).
REQ-035 Without VOICE_STEAL_EN, that case SHALL discard the command: drop pulses, no output change, no tx_req, return to IDLE.

Verification
REQ-036 Reset, then note-on key 60, fcw 0x00ABCD -> voice 0: fcw=0x00ABCD, note_en=0001; tx_req rises 2 edges after acceptance; ack 1 then 0 -> cmd_ready=1.
REQ-037 Note-on keys 60,62,64,65, then note-off key 62 -> note_en=1101; voice 1 FCW unchanged. Next note-on key 67 -> voice 1.
REQ-038 Four voices full, then note-on key 70: with VOICE_STEAL_EN, voice 0 (oldest) gets key 70; without it, drop pulses and note_en stays 1111 with no tx_req.
REQ-039 Note-off key 99 with no match -> drop 1 cycle, tx_req stays 0, cmd_ready returns 2 edges later.
REQ-040 Retrigger key 60 with fcw 0x001111 while enabled -> same voice updated and made youngest, with no second voice used. Then rst asserted during REQ -> tx_req=0 and all outputs 0 in the same cycle.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note on/off commands onto carrier voices with age-based
// ranking and a four-phase CDC handshake. Optional voice stealing via VOICE_STEAL_EN.
module voice_allocator #(
  parameter int unsigned N_VOICES  = 4,
  parameter int unsigned FCW_WIDTH = 24,
  parameter int unsigned KEY_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_on,
  input  logic [KEY_WIDTH-1:0]          cmd_key,
  input  logic [FCW_WIDTH-1:0]          cmd_fcw,
  output logic [N_VOICES*FCW_WIDTH-1:0] carrier_fcws,
  output logic [N_VOICES-1:0]           note_en,
  output logic                          tx_req,
  input  logic                          tx_ack,
  output logic                          drop
);

  localparam int unsigned IdxW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  typedef enum logic [1:0] {StIdle, StApply, StReq, StAckLow} state_e;
  typedef enum logic [1:0] {OpOn, OpOff, OpDrop} op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [IdxW-1:0]       sel_q, sel_d;
  logic [FCW_WIDTH-1:0]  cmd_fcw_q, cmd_fcw_d;
  logic [KEY_WIDTH-1:0]  cmd_key_q, cmd_key_d;
  logic                  drop_q, drop_d;

  logic [FCW_WIDTH-1:0]  voice_fcw_q [N_VOICES];
  logic [KEY_WIDTH-1:0]  voice_key_q [N_VOICES];
  logic [IdxW-1:0]       rank_q      [N_VOICES];
  logic [N_VOICES-1:0]   en_q;

  logic                  hit, free;
  logic [IdxW-1:0]       hit_idx, free_idx, old_idx;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    for (int i = int'(N_VOICES) - 1; i >= 0; i--) begin
      if (en_q[i] && (voice_key_q[i] == cmd_key)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!en_q[i]) begin
        free     = 1'b1;
        free_idx = IdxW'(i);
      end
      if (rank_q[i] == IdxW'(N_VOICES - 1)) old_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sel_d     = sel_q;
    cmd_fcw_d = cmd_fcw_q;
    cmd_key_d = cmd_key_q;
    drop_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = StApply;
          cmd_fcw_d = cmd_fcw;
          cmd_key_d = cmd_key;
          if (cmd_on) begin
            if (hit) begin
              op_d  = OpOn;
              sel_d = hit_idx;
            end else if (free) begin
              op_d  = OpOn;
              sel_d = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
              op_d  = OpOn;
              sel_d = old_idx;
`else
              op_d  = OpDrop;
              sel_d = '0;
`endif
            end
          end else begin
            op_d  = hit ? OpOff : OpDrop;
            sel_d = hit_idx;
          end
        end
      end
      StApply: begin
        if (op_q == OpDrop) begin
          state_d = StIdle;
          drop_d  = 1'b1;
        end else begin
          state_d = StReq;
        end
      end
      StReq:    if (tx_ack) state_d = StAckLow;
      StAckLow: if (!tx_ack) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpDrop;
      sel_q     <= '0;
      cmd_fcw_q <= '0;
      cmd_key_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      cmd_fcw_q <= cmd_fcw_d;
      cmd_key_q <= cmd_key_d;
      drop_q    <= drop_d;
    end
  end

  // Voice state is only written in APPLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      for (int i = 0; i < int'(N_VOICES); i++) begin
        voice_fcw_q[i] <= '0;
        voice_key_q[i] <= '0;
        rank_q[i]      <= IdxW'(i);
      end
    end else if (state_q == StApply) begin
      if (op_q == OpOn) begin
        voice_fcw_q[sel_q] <= cmd_fcw_q;
        voice_key_q[sel_q] <= cmd_key_q;
        en_q[sel_q]        <= 1'b1;
        for (int i = 0; i < int'(N_VOICES); i++) begin
          if (IdxW'(i) == sel_q) rank_q[i] <= '0;
          else if (rank_q[i] < rank_q[sel_q]) rank_q[i] <= rank_q[i] + 1'b1;
        end
      end else if (op_q == OpOff) begin
        en_q[sel_q] <= 1'b0;
      end
    end
  end

  always_comb begin
    carrier_fcws = '0;
    for (int i = 0; i < int'(N_VOICES); i++) begin
      carrier_fcws[i*FCW_WIDTH +: FCW_WIDTH] = voice_fcw_q[i];
    end
  end

  // rst gating keeps cmd_ready low while reset is held even though state is already IDLE.
  assign cmd_ready = (state_q == StIdle) && !rst;
  assign tx_req    = (state_q == StReq);
  assign note_en   = en_q;
  assign drop      = drop_q;

endmodule
